led_pulser_multi: RTL
=====================

# led_pulser_multi

Multi-channel successor to the single-LED controller in `sde_trigger`. It drives `NCH` LED outputs, each with its own delay, width and burst settings. A channel fires either a programmable delay after the GPS 1PPS edge or immediately on a software "fire now" edge. A shared trigger flag is raised at a fixed offset after each firing, so the trigger logic can tag the LED-induced events.

## Interface
Parameters:
- `NCH`, 2: number of LED channels.
- `DELAY_W`, 24: width of each channel's PPS-to-pulse delay field.
- `WIDTH_W`, 8: width of each channel's pulse-width field.
- `BURST_W`, 8: width of the burst-count and gap-period fields.
- `FLAG_DELAY`, 8'd10: cycles from first LED rise to `TRG_FLAG` rise, minus one.
- `FLAG_WIDTH`, 8'd4: `TRG_FLAG` high time, minus one.

Ports:
- `CLK120`  in  1  120 MHz system clock; the only clock.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `ONE_PPS`  in  1  asynchronous 1PPS; synchronised internally with 2 flops.
- `LED_NOW`  in  NCH  per-channel fire-now level, synchronous to `CLK120`; a rising edge triggers.
- `CFG_ENAPPS`  in  NCH  per-channel enable for PPS triggering.
- `CFG_DELAY`  in  NCH*DELAY_W  per-channel delay D; channel i uses slice [i*DELAY_W +: DELAY_W].
- `CFG_WIDTH`  in  NCH*WIDTH_W  per-channel width W.
- `CFG_COUNT`  in  NCH*BURST_W  per-channel pulses per trigger C.
- `CFG_GAP`  in  NCH*BURST_W  per-channel low gap G between burst pulses.
- `LED`  out  NCH  LED drive, active high, registered.
- `BUSY`  out  NCH  channel not IDLE, registered.
- `TRG_FLAG`  out  1  flag to the trigger logic, registered.

## Operation
- Each channel runs an independent FSM with states IDLE, DELAY, PULSE and GAP.
- `LED[i]` is 1 exactly when channel i is in PULSE.
- `BUSY[i]` is 1 when channel i is not in IDLE.
- IDLE → PULSE on a `LED_NOW[i]` rising edge (current sample 1, previous sample 0). W, C and G are latched; the pulse counter is loaded with W.
- IDLE → DELAY on a synchronised PPS rising edge when `CFG_ENAPPS[i]` is 1. D, W, C and G are latched.
- If both triggers occur in the same cycle, the `LED_NOW` trigger wins and the PPS edge is dropped.
- DELAY: the counter decrements each cycle. At 0, the FSM moves to PULSE with the counter loaded from the latched W.
- PULSE: the counter decrements each cycle. At 0:
  - if the remaining pulse count > 1, decrement it and go to GAP with the counter loaded from G;
  - otherwise go to IDLE.
- GAP: the counter decrements each cycle; at 0, go to PULSE with the counter loaded from W.
- Any trigger arriving while the channel is not IDLE is ignored; there is no queueing and no retrigger.
- Config inputs are sampled only at trigger time. Changes made mid-sequence take effect on the next trigger.
- C = 0 is treated as C = 1.
- Flag sequencer:
  - It arms when any channel enters PULSE for the first pulse of a trigger, and only if the sequencer is idle.
  - Triggers that arrive while it is armed or `TRG_FLAG` is high do not restart it.
  - Burst pulses after the first never arm it.

## Timing
- Reset (asynchronous assert, synchronous deassert via `CLK120`):
  - `LED`, `BUSY` and `TRG_FLAG` are 0; all FSMs are IDLE; all counters are 0; the sync and edge flops are 0.
  - An assertion mid-pulse drops `LED` in the same instant, with no clock needed.
- PPS path: `ONE_PPS` first sampled high at edge k gives DELAY at edge k+3. `LED` then rises at edge k+D+4.
- `LED_NOW` path: `LED_NOW[i]` first sampled high at edge j gives `LED` high from edge j.
- Pulse high time is exactly W+1 cycles, so W = 0 gives 1 cycle.
- The low time between burst pulses is exactly G+1 cycles.
- `TRG_FLAG` rises FLAG_DELAY+1 cycles after the triggering LED rise and stays high for FLAG_WIDTH+1 cycles.
- Counters wrap only through reload, never by underflow. D = 2^DELAY_W−1 is legal and gives the maximum delay.

## Configuration
- Macro `LED_BURST_EN`.
- Defined: GAP state and burst behaviour as described above.
- Undefined: the GAP state and the burst counters are not built. `CFG_COUNT` and `CFG_GAP` stay on the port list but are ignored. Every trigger produces exactly one pulse of W+1 cycles.

## Test plan
- PPS timing: NCH=2, channel 0 enabled with D=5, W=3. PPS rise at edge 100 → `LED[0]` high at edges 109–112. `LED[1]` stays 0.
- Fire now: `LED_NOW[1]` rises at edge 50 with W=0 → `LED[1]` high for exactly 1 cycle at edge 50. `TRG_FLAG` is high at edges 61–65 (FLAG_DELAY=10, FLAG_WIDTH=4).
- Burst (`LED_BURST_EN` defined): C=3, W=1, G=2 → three 2-cycle pulses separated by 3 low cycles. `BUSY` drops the cycle after the last pulse. Exactly one `TRG_FLAG` pulse.
- Collisions:
  - `LED_NOW` rising edge on the same cycle as a PPS edge → immediate pulse; the PPS delay never starts.
  - A second trigger during DELAY or PULSE → ignored.
- Reset mid-pulse: `RESET_N` is asserted low between clock edges while `LED[0]` is high. `LED[0]` falls before the next edge. After release, the channel is IDLE and waits for a new trigger.
- Burst compiled out (`LED_BURST_EN` undefined): C=3 → a single W+1 pulse, and `BUSY` clears immediately afterwards.

Source files
------------

// File: rtl/led_pulser_multi.sv
// led_pulser_multi: NCH LED pulse channels, fired by 1PPS + delay or by a
// fire-now edge, plus a shared trigger flag raised a fixed time after a firing.
// Ports: CLK120 clock; RESET_N async active-low reset; ONE_PPS async 1PPS;
//   LED_NOW[NCH] fire-now levels; CFG_ENAPPS[NCH] PPS enables;
//   CFG_DELAY/CFG_WIDTH/CFG_COUNT/CFG_GAP packed per-channel config
//   (channel i uses slice [i*W +: W]); LED[NCH], BUSY[NCH], TRG_FLAG outputs.
// Build option: define LED_BURST_EN to build the GAP state and burst counters;
//   without it CFG_COUNT/CFG_GAP are ignored and every trigger gives one pulse.
module led_pulser_multi #(
  parameter int NCH = 2,
  parameter int DELAY_W = 24,
  parameter int WIDTH_W = 8,
  parameter int BURST_W = 8,
  parameter logic [7:0] FLAG_DELAY = 8'd10,
  parameter logic [7:0] FLAG_WIDTH = 8'd4
) (
  input  logic                   CLK120,
  input  logic                   RESET_N,
  input  logic                   ONE_PPS,
  input  logic [NCH-1:0]         LED_NOW,
  input  logic [NCH-1:0]         CFG_ENAPPS,
  input  logic [NCH*DELAY_W-1:0] CFG_DELAY,
  input  logic [NCH*WIDTH_W-1:0] CFG_WIDTH,
  input  logic [NCH*BURST_W-1:0] CFG_COUNT,
  input  logic [NCH*BURST_W-1:0] CFG_GAP,
  output logic [NCH-1:0]         LED,
  output logic [NCH-1:0]         BUSY,
  output logic                   TRG_FLAG
);

  localparam int CW0 =
    (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
`ifdef LED_BURST_EN
  localparam int CNT_W =
    (CW0 > BURST_W) ? CW0 : BURST_W;
  localparam logic [BURST_W-1:0] B_ONE =
    BURST_W'(1);
`else
  localparam int CNT_W = CW0;
`endif
  localparam logic [CNT_W-1:0] C_ONE =
    CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_PULSE = 2'd2
`ifdef LED_BURST_EN
    , S_GAP = 2'd3
`endif
  } st_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_HIGH = 2'd2
  } fst_t;

`ifndef LED_BURST_EN
  logic unused_burst_cfg;
  assign unused_burst_cfg =
    ^{CFG_COUNT, CFG_GAP};
`endif

  // 2-flop PPS synchroniser, a history flop,
  // and a registered rising-edge pulse.
  logic pps_s1, pps_s2, pps_s3, pps_rise;
  logic [NCH-1:0] now_q;
  logic [NCH-1:0] now_rise;

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      pps_s1   <= 1'b0;
      pps_s2   <= 1'b0;
      pps_s3   <= 1'b0;
      pps_rise <= 1'b0;
      now_q    <= '0;
    end else begin
      pps_s1   <= ONE_PPS;
      pps_s2   <= pps_s1;
      pps_s3   <= pps_s2;
      pps_rise <= pps_s2 & ~pps_s3;
      now_q    <= LED_NOW;
    end
  end

  assign now_rise = LED_NOW & ~now_q;

  logic [NCH-1:0] led_n;
  logic [NCH-1:0] busy_n;
  logic [NCH-1:0] first_pulse;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    st_t state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH_W-1:0] w_q, w_n;
    logic [DELAY_W-1:0] d_in;
    logic [WIDTH_W-1:0] w_in;
`ifdef LED_BURST_EN
    logic [BURST_W-1:0] rem, rem_n;
    logic [BURST_W-1:0] g_q, g_n;
    logic [BURST_W-1:0] c_in, g_in;
    assign c_in = CFG_COUNT[i*BURST_W +: BURST_W];
    assign g_in = CFG_GAP[i*BURST_W +: BURST_W];
`endif
    assign d_in = CFG_DELAY[i*DELAY_W +: DELAY_W];
    assign w_in = CFG_WIDTH[i*WIDTH_W +: WIDTH_W];

    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      w_n     = w_q;
`ifdef LED_BURST_EN
      rem_n   = rem;
      g_n     = g_q;
`endif
      unique case (state)
        S_IDLE: begin
          // Fire-now has priority over a
          // coincident PPS edge.
          if (now_rise[i]) begin
            state_n = S_PULSE;
            cnt_n   = CNT_W'(w_in);
            w_n     = w_in;
`ifdef LED_BURST_EN
            rem_n = (c_in == '0) ? B_ONE : c_in;
            g_n   = g_in;
`endif
          end else if (pps_rise && CFG_ENAPPS[i]) begin
            state_n = S_DELAY;
            cnt_n   = CNT_W'(d_in);
            w_n     = w_in;
`ifdef LED_BURST_EN
            rem_n = (c_in == '0) ? B_ONE : c_in;
            g_n   = g_in;
`endif
          end
        end
        S_DELAY: begin
          if (cnt != '0) begin
            cnt_n = cnt - C_ONE;
          end else begin
            state_n = S_PULSE;
            cnt_n   = CNT_W'(w_q);
          end
        end
        S_PULSE: begin
          if (cnt != '0) begin
            cnt_n = cnt - C_ONE;
          end
`ifdef LED_BURST_EN
          else if (rem > B_ONE) begin
            rem_n   = rem - B_ONE;
            state_n = S_GAP;
            cnt_n   = CNT_W'(g_q);
          end
`endif
          else begin
            state_n = S_IDLE;
          end
        end
`ifdef LED_BURST_EN
        S_GAP: begin
          if (cnt != '0) begin
            cnt_n = cnt - C_ONE;
          end else begin
            state_n = S_PULSE;
            cnt_n   = CNT_W'(w_q);
          end
        end
`endif
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end

    always_ff @(posedge CLK120 or negedge RESET_N) begin
      if (!RESET_N) begin
        state <= S_IDLE;
        cnt   <= '0;
        w_q   <= '0;
`ifdef LED_BURST_EN
        rem   <= '0;
        g_q   <= '0;
`endif
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
        w_q   <= w_n;
`ifdef LED_BURST_EN
        rem   <= rem_n;
        g_q   <= g_n;
`endif
      end
    end

    assign led_n[i]  = (state_n == S_PULSE);
    assign busy_n[i] = (state_n != S_IDLE);
    // Only entries from IDLE/DELAY are first
    // pulses; GAP->PULSE never arms the flag.
    assign first_pulse[i] =
      (state_n == S_PULSE) &&
      ((state == S_IDLE) || (state == S_DELAY));
  end

  fst_t fst, fst_n;
  logic [7:0] fcnt, fcnt_n;

  always_comb begin
    fst_n  = fst;
    fcnt_n = fcnt;
    unique case (fst)
      F_IDLE: begin
        if (|first_pulse) begin
          fst_n  = F_WAIT;
          fcnt_n = FLAG_DELAY;
        end
      end
      F_WAIT: begin
        if (fcnt != 8'd0) begin
          fcnt_n = fcnt - 8'd1;
        end else begin
          fst_n  = F_HIGH;
          fcnt_n = FLAG_WIDTH;
        end
      end
      F_HIGH: begin
        if (fcnt != 8'd0) begin
          fcnt_n = fcnt - 8'd1;
        end else begin
          fst_n = F_IDLE;
        end
      end
      default: begin
        fst_n = F_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      fst      <= F_IDLE;
      fcnt     <= 8'd0;
      LED      <= '0;
      BUSY     <= '0;
      TRG_FLAG <= 1'b0;
    end else begin
      fst      <= fst_n;
      fcnt     <= fcnt_n;
      LED      <= led_n;
      BUSY     <= busy_n;
      TRG_FLAG <= (fst_n == F_HIGH);
    end
  end

endmodule
